// File: rtl/if_prefetch_pkg.sv
// ----------------------------------------------------------------------------
// if_prefetch_pkg
// Shared constants and types for the instruction-fetch front end.
//   InstAddrBus / InstBus : widths of instruction address and data buses
//   ZeroWord              : all-zero word driven on idle outputs
//   RstEnable             : level of rst that means "in reset"
//   ChipEnable/Disable    : ROM chip-enable levels
//   ResetPC               : first fetch address after reset
//   fetch_entry_t         : one queued fetch result {pc, inst}
//   word_align()          : clears the byte-offset bits of an address
// ----------------------------------------------------------------------------
package if_prefetch_pkg;

    localparam int          InstAddrBus = 32;
    localparam int          InstBus     = 32;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;
    localparam logic        RstEnable   = 1'b1;
    localparam logic        ChipEnable  = 1'b1;
    localparam logic        ChipDisable = 1'b0;
    localparam logic [31:0] ResetPC     = 32'h0000_0000;

    typedef struct packed {
        logic [InstAddrBus-1:0] pc;
        logic [InstBus-1:0]     inst;
    } fetch_entry_t;

    // Masking (rather than slicing) keeps every address bit referenced.
    function automatic logic [InstAddrBus-1:0] word_align(input logic [InstAddrBus-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/if_fifo.sv
// ----------------------------------------------------------------------------
// if_fifo
// Synchronous first-word-fall-through FIFO of fetch_entry_t (64-bit) entries.
//   clk, rst : clock and synchronous active-high reset
//   push     : write din at the tail (ignored when full)
//   pop      : advance the head (ignored when empty)
//   flush    : discard all entries; has priority over push/pop
//   full     : DEPTH entries held
//   empty    : no entries held
//   din      : entry to write
//   dout     : current head entry (meaningful only when not empty)
// ----------------------------------------------------------------------------
module if_fifo
    import if_prefetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    output logic         full,
    output logic         empty,
    input  fetch_entry_t din,
    output fetch_entry_t dout
);

    localparam int              AW         = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0]   PTR_ONE    = AW'(1);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst == RstEnable || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    // Storage is not reset; stale contents are never visible past the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/if_prefetch.sv
// ----------------------------------------------------------------------------
// if_prefetch
// Instruction-fetch front end: generates the fetch PC, reads the
// combinational instruction ROM and buffers {pc, inst} pairs in a small FWFT
// queue that the ID stage drains under a stall handshake. A branch redirect
// flushes the queue and restarts fetching at the target.
//   clk, rst             : clock and synchronous active-high reset
//   rom_ce_o, rom_addr_o : ROM chip enable and word-aligned byte address
//   rom_data_i           : ROM read data for the current address
//   stall_i              : ID cannot accept the head this cycle
//   branch_flag_i        : redirect request
//   branch_target_addr_i : redirect address (low two bits ignored)
//   id_valid_o           : queue head valid
//   id_pc_o, id_inst_o   : head entry, zero when the queue is empty
// ----------------------------------------------------------------------------
module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter int                     DEPTH    = 4,
    parameter logic [InstAddrBus-1:0] RESET_PC = ResetPC
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   rom_ce_o,
    output logic [InstAddrBus-1:0] rom_addr_o,
    input  logic [InstBus-1:0]     rom_data_i,
    input  logic                   stall_i,
    input  logic                   branch_flag_i,
    input  logic [InstAddrBus-1:0] branch_target_addr_i,
    output logic                   id_valid_o,
    output logic [InstAddrBus-1:0] id_pc_o,
    output logic [InstBus-1:0]     id_inst_o
);

    logic                   ce_en;
    logic [InstAddrBus-1:0] fetch_pc;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    fetch_entry_t           fifo_din;
    fetch_entry_t           fifo_dout;

    // No push-through: a full queue blocks fetch even if ID pops this cycle.
    assign rom_ce_o   = (ce_en == ChipEnable) & (rst != RstEnable) & ~branch_flag_i & ~fifo_full;
    assign rom_addr_o = word_align(fetch_pc);

    assign fifo_push = rom_ce_o;
    assign fifo_din  = '{pc: fetch_pc, inst: rom_data_i};
    // A redirect squashes the pop so nothing is consumed alongside the flush.
    assign fifo_pop  = id_valid_o & ~stall_i & ~branch_flag_i;

    assign id_valid_o = ~fifo_empty;
    assign id_pc_o    = id_valid_o ? fifo_dout.pc   : ZeroWord;
    assign id_inst_o  = id_valid_o ? fifo_dout.inst : ZeroWord;

    // ce_en holds fetch off for the first cycle after reset release.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            ce_en    <= ChipDisable;
            fetch_pc <= RESET_PC;
        end else begin
            ce_en <= ChipEnable;
            if (branch_flag_i) begin
                fetch_pc <= word_align(branch_target_addr_i);
            end else if (rom_ce_o) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
        end
    end

    if_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (branch_flag_i),
        .full  (fifo_full),
        .empty (fifo_empty),
        .din   (fifo_din),
        .dout  (fifo_dout)
    );

endmodule

// File: tb/tb_if_prefetch.sv
// ----------------------------------------------------------------------------
// tb_if_prefetch
// Self-checking bench for if_prefetch. A queue-based model of the fetch
// front end predicts every output each cycle; directed scenarios pin the
// model with hand-computed values, then randomized stall/branch/reset traffic
// runs against the same model. The ROM returns address + 0x100.
// ----------------------------------------------------------------------------
module tb_if_prefetch;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch;
    logic [31:0] target;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_data_i;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    bit          m_ce;
    bit          m_live = 1'b0;

    always #5 clk = ~clk;

    assign rom_data_i = rom_addr_o + 32'h0000_0100;

    if_prefetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .rom_ce_o             (rom_ce_o),
        .rom_addr_o           (rom_addr_o),
        .rom_data_i           (rom_data_i),
        .stall_i              (stall),
        .branch_flag_i        (branch),
        .branch_target_addr_i (target),
        .id_valid_o           (id_valid_o),
        .id_pc_o              (id_pc_o),
        .id_inst_o            (id_inst_o)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit s, input bit b, input logic [31:0] t);
        @(posedge clk);
        #1;
        rst    = r;
        stall  = s;
        branch = b;
        target = t;
    endtask

    // Reference model: a queue of fetched words plus the next fetch address.
    always @(posedge clk) begin : model
        bit do_pop;
        bit do_push;
        if (rst) begin
            mq.delete();
            m_pc   = 32'h0;
            m_ce   = 1'b0;
            m_live = 1'b1;
        end else if (m_live) begin
            if (branch) begin
                mq.delete();
                m_pc = target & ~32'h3;
            end else begin
                do_pop  = (mq.size() != 0) && !stall;
                do_push = m_ce && (mq.size() < DEPTH);
                if (do_pop) begin
                    void'(mq.pop_front());
                end
                if (do_push) begin
                    mq.push_back('{pc: m_pc, inst: m_pc + 32'h100});
                    m_pc = m_pc + 32'd4;
                end
            end
            m_ce = 1'b1;
        end
    end

    always @(negedge clk) begin : compare
        bit          e_valid;
        bit          e_ce;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        if (m_live) begin
            e_valid = (mq.size() != 0);
            e_pc    = e_valid ? mq[0].pc   : 32'h0;
            e_inst  = e_valid ? mq[0].inst : 32'h0;
            e_ce    = m_ce && !rst && !branch && (mq.size() < DEPTH);
            checkOutput("id_valid", {31'b0, id_valid_o}, {31'b0, e_valid});
            checkOutput("id_pc", id_pc_o, e_pc);
            checkOutput("id_inst", id_inst_o, e_inst);
            checkOutput("rom_ce", {31'b0, rom_ce_o}, {31'b0, e_ce});
            checkOutput("rom_addr", rom_addr_o, m_pc);
        end
    end

    initial begin
        bit          r;
        bit          s;
        bit          b;
        logic [31:0] t;

        rst    = 1'b1;
        stall  = 1'b0;
        branch = 1'b0;
        target = 32'h0;

        // Reset release and streaming.
        applyStimulus(1, 0, 0, 32'h0);
        applyStimulus(0, 0, 0, 32'h0);
        @(negedge clk);
        checkOutput("lit_ce_after_reset", {31'b0, rom_ce_o}, 32'h0);
        checkOutput("lit_valid_after_reset", {31'b0, id_valid_o}, 32'h0);
        checkOutput("lit_pc_after_reset", id_pc_o, 32'h0);
        applyStimulus(0, 0, 0, 32'h0);
        @(negedge clk);
        checkOutput("lit_first_ce", {31'b0, rom_ce_o}, 32'h1);
        checkOutput("lit_first_addr", rom_addr_o, 32'h0);
        applyStimulus(0, 0, 0, 32'h0);
        @(negedge clk);
        checkOutput("lit_stream_pc0", id_pc_o, 32'h0);
        checkOutput("lit_stream_inst0", id_inst_o, 32'h100);
        applyStimulus(0, 0, 0, 32'h0);
        @(negedge clk);
        checkOutput("lit_stream_pc1", id_pc_o, 32'h4);
        checkOutput("lit_stream_inst1", id_inst_o, 32'h104);
        applyStimulus(0, 0, 0, 32'h0);
        @(negedge clk);
        checkOutput("lit_stream_pc2", id_pc_o, 32'h8);
        checkOutput("lit_stream_inst2", id_inst_o, 32'h108);

        // Stall fills the queue, then drain.
        applyStimulus(1, 1, 0, 32'h0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 0, 32'h0);
            @(negedge clk);
            checkOutput("lit_full_ce", {31'b0, rom_ce_o}, 32'h0);
            checkOutput("lit_full_head", id_pc_o, 32'h0);
        end
        applyStimulus(0, 0, 0, 32'h0);
        @(negedge clk);
        checkOutput("lit_drain_pc0", id_pc_o, 32'h0);
        checkOutput("lit_drain_no_pushthrough", {31'b0, rom_ce_o}, 32'h0);
        applyStimulus(0, 0, 0, 32'h0);
        @(negedge clk);
        checkOutput("lit_drain_pc4", id_pc_o, 32'h4);
        checkOutput("lit_resume_addr", rom_addr_o, 32'h10);
        applyStimulus(0, 0, 0, 32'h0);
        @(negedge clk);
        checkOutput("lit_drain_pc8", id_pc_o, 32'h8);
        applyStimulus(0, 0, 0, 32'h0);
        @(negedge clk);
        checkOutput("lit_drain_pcC", id_pc_o, 32'hC);
        applyStimulus(0, 0, 0, 32'h0);
        @(negedge clk);
        checkOutput("lit_drain_pc10", id_pc_o, 32'h10);

        // Branch with three entries queued.
        applyStimulus(1, 1, 0, 32'h0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 32'h0);
        applyStimulus(0, 1, 1, 32'h0000_0203);
        @(negedge clk);
        checkOutput("lit_br_valid_same", {31'b0, id_valid_o}, 32'h1);
        checkOutput("lit_br_ce_same", {31'b0, rom_ce_o}, 32'h0);
        applyStimulus(0, 0, 0, 32'h0);
        @(negedge clk);
        checkOutput("lit_br_valid_next", {31'b0, id_valid_o}, 32'h0);
        checkOutput("lit_br_addr_next", rom_addr_o, 32'h200);
        applyStimulus(0, 0, 0, 32'h0);
        @(negedge clk);
        checkOutput("lit_br_pc", id_pc_o, 32'h200);
        checkOutput("lit_br_inst", id_inst_o, 32'h300);

        // Branch together with a pop on a full queue.
        applyStimulus(1, 1, 0, 32'h0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 32'h0);
        applyStimulus(0, 0, 1, 32'h0000_0400);
        @(negedge clk);
        checkOutput("lit_brfull_ce", {31'b0, rom_ce_o}, 32'h0);
        applyStimulus(0, 0, 0, 32'h0);
        @(negedge clk);
        checkOutput("lit_brfull_valid", {31'b0, id_valid_o}, 32'h0);
        applyStimulus(0, 0, 0, 32'h0);
        @(negedge clk);
        checkOutput("lit_brfull_pc", id_pc_o, 32'h400);

        // PC wraps past the top of the address space.
        applyStimulus(0, 0, 1, 32'hFFFF_FFF8);
        applyStimulus(0, 0, 0, 32'h0);
        applyStimulus(0, 0, 0, 32'h0);
        @(negedge clk);
        checkOutput("lit_wrap_pc0", id_pc_o, 32'hFFFF_FFF8);
        applyStimulus(0, 0, 0, 32'h0);
        @(negedge clk);
        checkOutput("lit_wrap_pc1", id_pc_o, 32'hFFFF_FFFC);
        applyStimulus(0, 0, 0, 32'h0);
        @(negedge clk);
        checkOutput("lit_wrap_pc2", id_pc_o, 32'h0);
        checkOutput("lit_wrap_inst2", id_inst_o, 32'h100);

        // Reset mid-stream with two entries queued.
        applyStimulus(0, 1, 0, 32'h0);
        applyStimulus(1, 0, 0, 32'h0);
        applyStimulus(0, 0, 0, 32'h0);
        @(negedge clk);
        checkOutput("lit_rst_valid", {31'b0, id_valid_o}, 32'h0);
        checkOutput("lit_rst_pc", id_pc_o, 32'h0);
        checkOutput("lit_rst_inst", id_inst_o, 32'h0);
        checkOutput("lit_rst_ce", {31'b0, rom_ce_o}, 32'h0);
        applyStimulus(0, 0, 0, 32'h0);
        @(negedge clk);
        checkOutput("lit_rst_restart_ce", {31'b0, rom_ce_o}, 32'h1);
        checkOutput("lit_rst_restart_addr", rom_addr_o, 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 99) < 2);
            s = ($urandom_range(0, 99) < 40);
            b = ($urandom_range(0, 99) < 8);
            if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else t = $urandom;
            applyStimulus(r, s, b, t);
        end

        applyStimulus(0, 0, 0, 32'h0);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
